// File: rtl/e1_rx_buf_pack.sv
// Packs received E1 timeslot bytes into 32-bit memory words and queues them
// through a 2-entry FIFO that feeds a req/ack memory write port.
module e1_rx_buf_pack #(
  parameter int unsigned MFW = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic [4:0]       in_ts,
  input  logic [3:0]       in_frame,
  input  logic [MFW-1:0]   in_mf,
  input  logic             in_we,
  output logic             in_rdy,
  input  logic             ctl_flush,
  output logic [MFW+6:0]   mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wmsk,
  output logic             mem_req,
  input  logic             mem_ack,
  output logic             stat_drop
);

  localparam int unsigned AW = MFW + 7;

  logic [AW-1:0] pk_addr_q, pk_addr_d;
  logic [31:0]   pk_data_q, pk_data_d;
  logic [3:0]    pk_mask_q, pk_mask_d;

  logic [AW-1:0] q_addr_q [2];
  logic [31:0]   q_data_q [2];
  logic [3:0]    q_mask_q [2];
  logic          rd_q, wr_q;
  logic [1:0]    cnt_q, cnt_d;
  logic          stat_drop_q;

  logic [AW-1:0] in_addr;
  logic [1:0]    lane;
  logic          accept, pop, push, pk_empty, same_word;
  logic [31:0]   mrg_data, new_data;
  logic [3:0]    mrg_mask;
  logic [AW-1:0] push_addr;
  logic [31:0]   push_data;
  logic [3:0]    push_mask;

  assign in_addr   = {in_mf, in_frame, in_ts[4:2]};
  assign lane      = in_ts[1:0];
  assign in_rdy    = (cnt_q != 2'd2);
  assign accept    = in_we & in_rdy;
  assign mem_req   = (cnt_q != 2'd0);
  assign pop       = mem_req & mem_ack;
  assign pk_empty  = (pk_mask_q == 4'd0);
  assign same_word = pk_empty | (in_addr == pk_addr_q);

  assign mem_addr  = q_addr_q[rd_q];
  assign mem_wdata = q_data_q[rd_q];
  assign mem_wmsk  = q_mask_q[rd_q];
  assign stat_drop = stat_drop_q;

  always_comb begin
    mrg_data = pk_data_q;
    mrg_data[{lane, 3'b000} +: 8] = in_data;
    mrg_mask = pk_mask_q | (4'b0001 << lane);
    new_data = '0;
    new_data[{lane, 3'b000} +: 8] = in_data;
  end

  // A new-word byte with flush (or lane 3) would need two pushes: the old
  // partial goes out and the new byte stays in the packer.
  always_comb begin
    pk_addr_d = pk_addr_q;
    pk_data_d = pk_data_q;
    pk_mask_d = pk_mask_q;
    push      = 1'b0;
    push_addr = pk_addr_q;
    push_data = pk_data_q;
    push_mask = pk_mask_q;
    if (accept) begin
      if (same_word) begin
        if (lane == 2'd3 || ctl_flush) begin
          push      = 1'b1;
          push_addr = in_addr;
          push_data = mrg_data;
          push_mask = mrg_mask;
          pk_data_d = '0;
          pk_mask_d = '0;
        end else begin
          pk_addr_d = in_addr;
          pk_data_d = mrg_data;
          pk_mask_d = mrg_mask;
        end
      end else begin
        push      = 1'b1;
        pk_addr_d = in_addr;
        pk_data_d = new_data;
        pk_mask_d = 4'b0001 << lane;
      end
    end else if (ctl_flush && !pk_empty && (in_rdy || pop)) begin
      push      = 1'b1;
      pk_data_d = '0;
      pk_mask_d = '0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pk_addr_q   <= '0;
      pk_data_q   <= '0;
      pk_mask_q   <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
      stat_drop_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        q_addr_q[i] <= '0;
        q_data_q[i] <= '0;
        q_mask_q[i] <= '0;
      end
    end else begin
      pk_addr_q   <= pk_addr_d;
      pk_data_q   <= pk_data_d;
      pk_mask_q   <= pk_mask_d;
      cnt_q       <= cnt_d;
      stat_drop_q <= in_we & ~in_rdy;
      if (push) begin
        q_addr_q[wr_q] <= push_addr;
        q_data_q[wr_q] <= push_data;
        q_mask_q[wr_q] <= push_mask;
        wr_q           <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
    end
  end

endmodule

// File: tb/tb_e1_rx_buf_pack.sv
// Scoreboard bench for e1_rx_buf_pack: expected words are queued as bytes are
// driven and compared when the memory port accepts a write.
module tb_e1_rx_buf_pack;

  localparam int unsigned MFW = 7;

  logic           clk, rst;
  logic [7:0]     in_data;
  logic [4:0]     in_ts;
  logic [3:0]     in_frame;
  logic [MFW-1:0] in_mf;
  logic           in_we, in_rdy, ctl_flush;
  logic [13:0]    mem_addr;
  logic [31:0]    mem_wdata;
  logic [3:0]     mem_wmsk;
  logic           mem_req, mem_ack, stat_drop;

  int n_tests = 0;
  int n_fail  = 0;
  int req_cnt = 0;

  logic [49:0] sb [$];
  logic        hold = 1'b0;
  logic [49:0] held;

  e1_rx_buf_pack #(.MFW(MFW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_ts     (in_ts),
    .in_frame  (in_frame),
    .in_mf     (in_mf),
    .in_we     (in_we),
    .in_rdy    (in_rdy),
    .ctl_flush (ctl_flush),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmsk  (mem_wmsk),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .stat_drop (stat_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane_bits(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  function automatic logic [49:0] mk(input logic [6:0] mf, input logic [3:0] fr,
                                     input logic [2:0] wts, input logic [31:0] d,
                                     input logic [3:0] m);
    return {mf, fr, wts, d, m};
  endfunction

  // Memory-side monitor: compares each accepted write and checks hold stability.
  always @(negedge clk) begin
    logic [49:0] e;
    if (!rst && mem_req) begin
      req_cnt++;
      if (hold) check("stable", {mem_addr, mem_wdata, mem_wmsk}, held);
      if (mem_ack) begin
        hold = 1'b0;
        if (sb.size() == 0) begin
          check("extra_write", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check("addr", mem_addr, e[49:36]);
          check("wmsk", mem_wmsk, e[3:0]);
          check("wdata", mem_wdata & lane_bits(e[3:0]), e[35:4] & lane_bits(e[3:0]));
        end
      end else begin
        hold = 1'b1;
        held = {mem_addr, mem_wdata, mem_wmsk};
      end
    end else begin
      hold = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [4:0] ts, input logic [3:0] fr,
                      input logic [6:0] mf, input logic flush);
    in_data = d; in_ts = ts; in_frame = fr; in_mf = mf; in_we = 1'b1; ctl_flush = flush;
    tick();
    in_we = 1'b0; ctl_flush = 1'b0;
  endtask

  task automatic send_word(input logic [6:0] mf, input logic [3:0] fr, input logic [2:0] wts,
                           input logic [31:0] d);
    for (int n = 0; n < 4; n++) begin
      logic [1:0] ln;
      ln = 2'(n);
      send(d[8*n +: 8], {wts, ln}, fr, mf, 1'b0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", sb.size(), 0);
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_ts = '0; in_frame = '0; in_mf = '0;
    in_we = 1'b0; ctl_flush = 1'b0; mem_ack = 1'b0;
    tick(); tick();
    check("rst_req", mem_req, 0);
    check("rst_rdy", in_rdy, 1);
    check("rst_drop", stat_drop, 0);
    check("rst_out", {mem_addr, mem_wdata, mem_wmsk}, 0);
    rst = 1'b0;
    tick();

    // Full word, constant ack: exactly one write cycle
    mem_ack = 1'b1; req_cnt = 0;
    sb.push_back(mk(7'd1, 4'd2, 3'd1, 32'h44332211, 4'hF));
    send_word(7'd1, 4'd2, 3'd1, 32'h44332211);
    drain();
    tick(); tick();
    check("one_req_cycle", req_cnt, 1);

    // Word change pushes the partial, flush pushes the single lane
    send(8'hA0, 5'd0, 4'd0, 7'd0, 1'b0);
    send(8'hA1, 5'd1, 4'd0, 7'd0, 1'b0);
    sb.push_back(mk(7'd0, 4'd0, 3'd0, 32'h0000A1A0, 4'h3));
    send(8'hB8, 5'd8, 4'd0, 7'd0, 1'b0);
    sb.push_back(mk(7'd0, 4'd0, 3'd2, 32'h000000B8, 4'h1));
    ctl_flush = 1'b1; tick(); ctl_flush = 1'b0;
    drain();

    // Back-pressure: two words queue, the third is dropped byte by byte
    mem_ack = 1'b0;
    sb.push_back(mk(7'd5, 4'd1, 3'd0, 32'h13121110, 4'hF));
    sb.push_back(mk(7'd5, 4'd1, 3'd1, 32'h17161514, 4'hF));
    send_word(7'd5, 4'd1, 3'd0, 32'h13121110);
    send_word(7'd5, 4'd1, 3'd1, 32'h17161514);
    check("full_rdy", in_rdy, 0);
    for (int n = 0; n < 4; n++) begin
      logic [1:0] ln;
      ln = 2'(n);
      send(8'h20 + 8'(n), {3'd2, ln}, 4'd1, 7'd5, 1'b0);
      check("drop_pulse", stat_drop, 1);
    end
    tick();
    check("drop_clear", stat_drop, 0);
    mem_ack = 1'b1;
    drain();

    // Full queue: pop and completing byte in the same cycle
    mem_ack = 1'b0;
    sb.push_back(mk(7'd3, 4'd0, 3'd0, 32'h33323130, 4'hF));
    sb.push_back(mk(7'd3, 4'd0, 3'd1, 32'h37363534, 4'hF));
    send_word(7'd3, 4'd0, 3'd0, 32'h33323130);
    send_word(7'd3, 4'd0, 3'd1, 32'h37363534);
    check("full_rdy2", in_rdy, 0);
    mem_ack = 1'b1;
    send(8'hC3, 5'd11, 4'd0, 7'd3, 1'b0);
    mem_ack = 1'b0;
    check("rej_drop", stat_drop, 1);
    check("rej_rdy", in_rdy, 1);
    sb.push_back(mk(7'd3, 4'd0, 3'd2, 32'hD3000000, 4'h8));
    send(8'hD3, 5'd11, 4'd0, 7'd3, 1'b0);
    check("acc_drop", stat_drop, 0);
    check("acc_rdy", in_rdy, 0);
    mem_ack = 1'b1;
    drain();

    // Reset mid-operation discards queued and packed data
    mem_ack = 1'b0;
    send_word(7'd6, 4'd3, 3'd4, 32'h47464544);
    send(8'h50, 5'd20, 4'd3, 7'd6, 1'b0);
    send(8'h51, 5'd21, 4'd3, 7'd6, 1'b0);
    check("pre_rst_req", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_rdy", in_rdy, 1);
    tick();
    rst = 1'b0;
    mem_ack = 1'b1; req_cnt = 0;
    repeat (10) tick();
    check("no_req_after_rst", req_cnt, 0);

    // Flush coincident with a lane-2 byte into a packer holding lane 0
    req_cnt = 0;
    send(8'h5A, 5'd0, 4'd0, 7'd4, 1'b0);
    sb.push_back(mk(7'd4, 4'd0, 3'd0, 32'h00A5005A, 4'h5));
    send(8'hA5, 5'd2, 4'd0, 7'd4, 1'b1);
    ctl_flush = 1'b1; tick(); ctl_flush = 1'b0;
    drain();
    repeat (4) tick();
    check("flush_single", req_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
